// File: rtl/debounce_multi.sv
// Multi-channel button conditioner: synchroniser, tick-sampled debounce,
// and press/release/long-press pulse generation on a shared slow tick.
module debounce_multi #(
  parameter int N_CH         = 4,
  parameter int TICK_DIV     = 999999,
  parameter int STABLE_TICKS = 3,
  parameter int LONG_TICKS   = 100,
  parameter bit ACTIVE_LOW   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic            tick,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_long
);

  localparam int DW = (TICK_DIV > 0) ? $clog2(TICK_DIV + 1) : 1;
  localparam int SW = $clog2(STABLE_TICKS + 1);
  localparam int LW = $clog2(LONG_TICKS + 1);

  localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV);
  localparam logic [SW-1:0] SC_MAX  = SW'(STABLE_TICKS - 1);
  localparam logic [LW-1:0] LC_MAX  = LW'(LONG_TICKS);
  localparam logic [LW-1:0] LC_PRE  = LW'(LONG_TICKS - 1);

  logic [DW-1:0]   div_q, div_d;
  logic [N_CH-1:0] s1_q, s1_d;
  logic [N_CH-1:0] s2_q, s2_d;
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] press_q, press_d;
  logic [N_CH-1:0] rel_q, rel_d;
  logic [N_CH-1:0] long_q, long_d;
  logic [SW-1:0]   sc_q [N_CH];
  logic [SW-1:0]   sc_d [N_CH];
  logic [LW-1:0]   lc_q [N_CH];
  logic [LW-1:0]   lc_d [N_CH];

  assign tick = (div_q == DIV_MAX);

  always_comb begin
    div_d   = tick ? '0 : div_q + DW'(1);
    s1_d    = btn_in ^ {N_CH{ACTIVE_LOW}};
    s2_d    = s1_q;
    level_d = level_q;
    long_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      sc_d[i] = sc_q[i];
      lc_d[i] = lc_q[i];
      if (tick) begin
        if (s2_q[i] == level_q[i]) begin
          sc_d[i] = '0;
        end else if (sc_q[i] == SC_MAX) begin
          level_d[i] = s2_q[i];
          sc_d[i]    = '0;
        end else begin
          sc_d[i] = sc_q[i] + SW'(1);
        end
      end
      // lc only advances on ticks where the old level was already high
      if (!level_q[i]) begin
        lc_d[i] = '0;
      end else if (tick && (lc_q[i] != LC_MAX)) begin
        lc_d[i]   = lc_q[i] + LW'(1);
        long_d[i] = (lc_q[i] == LC_PRE);
      end
    end
    press_d = level_d & ~level_q;
    rel_d   = ~level_d & level_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      long_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        sc_q[i] <= '0;
        lc_q[i] <= '0;
      end
    end else begin
      div_q   <= div_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      for (int i = 0; i < N_CH; i++) begin
        sc_q[i] <= sc_d[i];
        lc_q[i] <= lc_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = rel_q;
  assign btn_long    = long_q;

endmodule
